// File: rtl/irq_target_arbiter.sv
// Per-target interrupt arbiter: captures rising edges into sticky pending bits and offers one
// eligible source at a time, round-robin, over valid/ready, tracking in-service until completion.
module irq_target_arbiter #(
  parameter int NumIntrSrc = 64,
  parameter int IdWidth    = (NumIntrSrc > 1) ? $clog2(NumIntrSrc) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumIntrSrc-1:0] irqs_i,
  input  logic                  enable_i,
  output logic                  irq_valid_o,
  input  logic                  irq_ready_i,
  output logic [IdWidth-1:0]    irq_id_o,
  input  logic                  cmpl_valid_i,
  input  logic [IdWidth-1:0]    cmpl_id_i,
  output logic [NumIntrSrc-1:0] pending_o,
  output logic [NumIntrSrc-1:0] in_service_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                r_state;
  logic [NumIntrSrc-1:0] r_irqQ;
  logic [NumIntrSrc-1:0] r_pending;
  logic [NumIntrSrc-1:0] r_inService;
  logic [IdWidth-1:0]    r_rrPtr;
  logic [IdWidth-1:0]    r_irqId;
  logic                  r_irqValid;

  logic [NumIntrSrc-1:0] w_rise;
  logic [NumIntrSrc-1:0] w_elig;
  logic [NumIntrSrc-1:0] w_claimMask;
  logic [NumIntrSrc-1:0] w_cmplMask;
  logic                  w_claim;
  logic                  w_selFound;
  logic [IdWidth-1:0]    w_selId;
  logic [IdWidth-1:0]    w_rrNext;

  assign w_rise   = irqs_i & ~r_irqQ;
  assign w_elig   = r_pending & ~r_inService;
  assign w_claim  = (r_state == OFFER) && r_irqValid && irq_ready_i;
  assign w_rrNext = (r_irqId == IdWidth'(NumIntrSrc - 1)) ? '0 : r_irqId + IdWidth'(1);

  // Round-robin scan starting at r_rrPtr, wrapping at NumIntrSrc (need not be a power of two).
  always_comb begin
    int idx;
    idx        = 0;
    w_selFound = 1'b0;
    w_selId    = '0;
    for (int k = 0; k < NumIntrSrc; k++) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= NumIntrSrc) idx = idx - NumIntrSrc;
      if (!w_selFound && w_elig[idx]) begin
        w_selFound = 1'b1;
        w_selId    = IdWidth'(idx);
      end
    end
  end

  // Out-of-range completion IDs match no bit, so they are ignored naturally.
  always_comb begin
    w_claimMask = '0;
    w_cmplMask  = '0;
    for (int i = 0; i < NumIntrSrc; i++) begin
      w_claimMask[i] = w_claim && (r_irqId == IdWidth'(i));
      w_cmplMask[i]  = cmpl_valid_i && (cmpl_id_i == IdWidth'(i));
    end
  end

  // A new edge beats a claim on pending; a claim beats a completion on in-service.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_irqQ      <= '0;
      r_pending   <= '0;
      r_inService <= '0;
      r_rrPtr     <= '0;
      r_irqId     <= '0;
      r_irqValid  <= 1'b0;
    end else begin
      r_irqQ      <= irqs_i;
      r_pending   <= (r_pending & ~w_claimMask) | w_rise;
      r_inService <= (r_inService & ~w_cmplMask) | w_claimMask;
      case (r_state)
        IDLE: begin
          if (enable_i && w_selFound) begin
            r_irqId    <= w_selId;
            r_irqValid <= 1'b1;
            r_state    <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ready_i) begin
            r_rrPtr    <= w_rrNext;
            r_irqValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_irqValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid_o  = r_irqValid;
  assign irq_id_o     = r_irqId;
  assign pending_o    = r_pending;
  assign in_service_o = r_inService;

endmodule

// File: tb/tb_irq_target_arbiter.sv
// Self-checking bench for irq_target_arbiter with 8 sources: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_irq_target_arbiter;

  localparam int N = 8;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] irqs_i;
  logic       enable_i;
  logic       irq_valid_o;
  logic       irq_ready_i;
  logic [2:0] irq_id_o;
  logic       cmpl_valid_i;
  logic [2:0] cmpl_id_i;
  logic [7:0] pending_o;
  logic [7:0] in_service_o;

  int errors = 0;
  int checks = 0;

  bit [7:0] mIrqQ, mPend, mIns;
  bit       mValid;
  int       mId, mRr;

  irq_target_arbiter #(.NumIntrSrc(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .irqs_i       (irqs_i),
    .enable_i     (enable_i),
    .irq_valid_o  (irq_valid_o),
    .irq_ready_i  (irq_ready_i),
    .irq_id_o     (irq_id_o),
    .cmpl_valid_i (cmpl_valid_i),
    .cmpl_id_i    (cmpl_id_i),
    .pending_o    (pending_o),
    .in_service_o (in_service_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference behaviour: one clock edge worth of state change, written from the rules directly.
  function automatic void model_step();
    bit [7:0] rise, elig, nPend, nIns;
    bit       nValid;
    int       nId, nRr, j;
    if (rst_i) begin
      mIrqQ = '0; mPend = '0; mIns = '0; mValid = 0; mId = 0; mRr = 0;
      return;
    end
    rise   = irqs_i & ~mIrqQ;
    elig   = mPend & ~mIns;
    nPend  = mPend;
    nIns   = mIns;
    nValid = mValid;
    nId    = mId;
    nRr    = mRr;
    if (cmpl_valid_i && int'(cmpl_id_i) < N) nIns[cmpl_id_i] = 1'b0;
    if (mValid) begin
      if (irq_ready_i) begin
        nPend[mId] = 1'b0;
        nIns[mId]  = 1'b1;
        nRr        = (mId + 1) % N;
        nValid     = 1'b0;
      end
    end else if (enable_i && elig != 0) begin
      for (int k = 0; k < N; k++) begin
        j = (mRr + k) % N;
        if (elig[j]) begin
          nId    = j;
          nValid = 1'b1;
          break;
        end
      end
    end
    nPend  = nPend | rise;
    mPend  = nPend;
    mIns   = nIns;
    mValid = nValid;
    mId    = nId;
    mRr    = nRr;
    mIrqQ  = irqs_i;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1; irqs_i = '0; enable_i = 0; irq_ready_i = 0; cmpl_valid_i = 0; cmpl_id_i = '0;
    tick();
    tick();
    rst_i = 0;
  endtask

  task automatic wait_valid(input int maxCycles, output bit ok);
    ok = 0;
    for (int n = 0; n < maxCycles; n++) begin
      if (irq_valid_o === 1'b1) begin
        ok = 1;
        return;
      end
      tick();
    end
    if (irq_valid_o === 1'b1) ok = 1;
  endtask

  task automatic test_reset();
    rst_i = 1; irqs_i = 8'hFF; enable_i = 1; irq_ready_i = 0; cmpl_valid_i = 0; cmpl_id_i = '0;
    tick();
    tick();
    checks++;
    if (irq_valid_o !== 1'b0 || irq_id_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_offer: valid=%0b id=%0d expected valid=0 id=0", irq_valid_o, irq_id_o);
    end
    checks++;
    if (pending_o !== 8'h00 || in_service_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_status: pending=%h in_service=%h expected 00/00", pending_o, in_service_o);
    end
    rst_i = 0;
    tick();
    checks++;
    if (pending_o !== 8'hFF || irq_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cycle1: pending=%h valid=%0b expected pending=ff valid=0", pending_o, irq_valid_o);
    end
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_cycle2: valid=%0b id=%0d expected valid=1 id=0", irq_valid_o, irq_id_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    enable_i = 1; irq_ready_i = 1;
    irqs_i = 8'h08;
    tick();
    irqs_i = 8'h00;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd3) begin
      errors++;
      $display("[TB] FAIL single_offer: valid=%0b id=%0d expected valid=1 id=3", irq_valid_o, irq_id_o);
    end
    tick();
    checks++;
    if (in_service_o !== 8'h08 || pending_o !== 8'h00 || irq_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_claim: in_service=%h pending=%h valid=%0b expected 08/00/0",
               in_service_o, pending_o, irq_valid_o);
    end
    cmpl_valid_i = 1; cmpl_id_i = 3'd3;
    tick();
    cmpl_valid_i = 0;
    checks++;
    if (in_service_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_cmpl: in_service=%h expected 00", in_service_o);
    end
  endtask

  task automatic test_round_robin();
    int expIds[3] = '{0, 2, 4};
    bit ok;
    int got;
    do_reset();
    enable_i = 1; irq_ready_i = 1;
    irqs_i = 8'h15;
    for (int i = 0; i < 3; i++) begin
      wait_valid(10, ok);
      got = int'(irq_id_o);
      checks++;
      if (!ok || got != expIds[i]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: offered=%0b id=%0d expected id=%0d", i, ok, got, expIds[i]);
      end
      tick();
      cmpl_valid_i = 1; cmpl_id_i = irq_id_o;
      tick();
      cmpl_valid_i = 0;
    end
    irqs_i = 8'h00;
    tick();
    irqs_i = 8'h01;
    wait_valid(10, ok);
    checks++;
    if (!ok || irq_id_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rr_wrap: offered=%0b id=%0d expected id=0", ok, irq_id_o);
    end
    tick();
  endtask

  task automatic test_hold_offer();
    bit ok;
    int badCycles;
    do_reset();
    enable_i = 1; irq_ready_i = 0;
    irqs_i = 8'h20;
    tick();
    irqs_i = 8'h00;
    wait_valid(10, ok);
    checks++;
    if (!ok || irq_id_o !== 3'd5) begin
      errors++;
      $display("[TB] FAIL hold_first: offered=%0b id=%0d expected id=5", ok, irq_id_o);
    end
    badCycles = 0;
    for (int i = 0; i < 10; i++) begin
      enable_i = i[0];
      irqs_i = (i == 3) ? 8'h02 : 8'h00;
      tick();
      if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd5) badCycles++;
    end
    checks++;
    if (badCycles != 0) begin
      errors++;
      $display("[TB] FAIL hold_stable: %0d cycles lost id 5 offer, expected 0", badCycles);
    end
    checks++;
    if (pending_o !== 8'h22) begin
      errors++;
      $display("[TB] FAIL hold_pending: pending=%h expected 22", pending_o);
    end
  endtask

  task automatic test_in_service();
    bit ok;
    do_reset();
    enable_i = 1; irq_ready_i = 1;
    irqs_i = 8'h40;
    tick();
    irqs_i = 8'h00;
    wait_valid(10, ok);
    tick();
    irqs_i = 8'h40;
    tick();
    irqs_i = 8'h00;
    tick();
    tick();
    checks++;
    if (pending_o !== 8'h40 || in_service_o !== 8'h40 || irq_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL insvc_blocked: pending=%h in_service=%h valid=%0b expected 40/40/0",
               pending_o, in_service_o, irq_valid_o);
    end
    cmpl_valid_i = 1; cmpl_id_i = 3'd2;
    tick();
    cmpl_valid_i = 0;
    checks++;
    if (pending_o !== 8'h40 || in_service_o !== 8'h40 || irq_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL insvc_ignore_cmpl: pending=%h in_service=%h valid=%0b expected 40/40/0",
               pending_o, in_service_o, irq_valid_o);
    end
    cmpl_valid_i = 1; cmpl_id_i = 3'd6;
    tick();
    cmpl_valid_i = 0;
    checks++;
    if (in_service_o !== 8'h00 || irq_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL insvc_cmpl_edge: in_service=%h valid=%0b expected 00/0", in_service_o, irq_valid_o);
    end
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd6) begin
      errors++;
      $display("[TB] FAIL insvc_reoffer: valid=%0b id=%0d expected valid=1 id=6", irq_valid_o, irq_id_o);
    end
  endtask

  task automatic test_reset_mid_offer();
    bit ok;
    do_reset();
    enable_i = 1; irq_ready_i = 1;
    irqs_i = 8'h02;
    tick();
    irqs_i = 8'h00;
    wait_valid(10, ok);
    tick();
    irq_ready_i = 0;
    irqs_i = 8'h04;
    tick();
    irqs_i = 8'h00;
    wait_valid(10, ok);
    checks++;
    if (!ok || irq_id_o !== 3'd2 || in_service_o !== 8'h02) begin
      errors++;
      $display("[TB] FAIL midrst_setup: offered=%0b id=%0d in_service=%h expected id=2 in_service=02",
               ok, irq_id_o, in_service_o);
    end
    rst_i = 1;
    tick();
    rst_i = 0;
    checks++;
    if (irq_valid_o !== 1'b0 || pending_o !== 8'h00 || in_service_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_clear: valid=%0b pending=%h in_service=%h expected 0/00/00",
               irq_valid_o, pending_o, in_service_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst_i        = ($urandom_range(0, 249) == 0);
      irqs_i       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : irqs_i;
      enable_i     = ($urandom_range(0, 4) != 0);
      irq_ready_i  = ($urandom_range(0, 2) != 0);
      cmpl_valid_i = ($urandom_range(0, 2) == 0);
      cmpl_id_i    = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (irq_valid_o !== mValid) begin
        errors++;
        $display("[TB] FAIL rand_valid@%0d: got %0b expected %0b", c, irq_valid_o, mValid);
      end
      checks++;
      if (irq_id_o !== 3'(mId)) begin
        errors++;
        $display("[TB] FAIL rand_id@%0d: got %0d expected %0d", c, irq_id_o, mId);
      end
      checks++;
      if (pending_o !== mPend) begin
        errors++;
        $display("[TB] FAIL rand_pending@%0d: got %h expected %h", c, pending_o, mPend);
      end
      checks++;
      if (in_service_o !== mIns) begin
        errors++;
        $display("[TB] FAIL rand_in_service@%0d: got %h expected %h", c, in_service_o, mIns);
      end
    end
    rst_i = 0; cmpl_valid_i = 0;
  endtask

  initial begin
    rst_i = 1; irqs_i = '0; enable_i = 0; irq_ready_i = 0; cmpl_valid_i = 0; cmpl_id_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_offer();
    test_in_service();
    test_reset_mid_offer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
